hb_up2_axis_pack: RTL and testbench

Downstream stage of the half-band x2 interpolator. Takes the two-samples-per-clock output pair and its overflow flag. Packs each pair into one word and buffers it in a small FIFO. Presents the words on an AXI4-Stream master with backpressure, and keeps saturating counters of overflowed and dropped pairs for status registers.

---
 rtl/hb_up2_axis_pack.sv | 114 +++++++++++
 tb/tb_hb_up2_axis_pack.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hb_up2_axis_pack.sv
// Packs interpolator output pairs into {din1, din0} words, buffers them in a
// show-ahead FIFO and streams them out over AXI4-Stream with overflow/drop status.
module hb_up2_axis_pack #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         din0,
    input  logic [DATA_WIDTH-1:0]         din1,
    input  logic                          din_ovf,
    input  logic                          din_valid,
    output logic [2*DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [FIFO_DEPTH_LOG2:0]      fifo_level,
    output logic                          full,
    output logic [CNT_WIDTH-1:0]          ovf_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    input  logic                          cnt_clr
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int EW    = 2 * DATA_WIDTH + 1;

    localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
    localparam logic [LW-1:0]        LVL_ONE   = LW'(1);
    localparam logic [LW-1:0]        DEPTH_LVL = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [EW-1:0]        mem_q [0:DEPTH-1];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, full_d;
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic tvalid;
    logic pop;
    logic push;
    logic drop;

    assign tvalid = (level_q != '0);
    assign pop    = tvalid & m_axis_tready;
    // A full FIFO still accepts a pair when the head leaves in the same cycle.
    assign push   = din_valid & (~full_q | pop);
    assign drop   = din_valid & full_q & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_cnt_d  = ovf_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Clear wins over a coincident increment, so that event is lost.
        if (cnt_clr) begin
            ovf_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (push && din_ovf && ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            if (drop && drop_cnt_q != CNT_MAX)           drop_cnt_d = drop_cnt_q + CNT_ONE;
        end

        full_d = (level_d == DEPTH_LVL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            ovf_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            ovf_cnt_q  <= ovf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while tvalid is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {din_ovf, din1, din0};
    end

    assign m_axis_tdata  = mem_q[rd_ptr_q][2*DATA_WIDTH-1:0];
    assign m_axis_tuser  = mem_q[rd_ptr_q][2*DATA_WIDTH];
    assign m_axis_tvalid = tvalid;
    assign fifo_level    = level_q;
    assign full          = full_q;
    assign ovf_cnt       = ovf_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_hb_up2_axis_pack.sv
// Directed bench for hb_up2_axis_pack: vector table plus multi-cycle sequences
// for fill/backpressure, full-with-pop, overflow tagging, saturation and reset.
module tb_hb_up2_axis_pack;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din0, din1;
    logic          din_ovf, din_valid;
    logic [2*DW-1:0] m_axis_tdata;
    logic          m_axis_tuser, m_axis_tvalid, m_axis_tready;
    logic [FL:0]   fifo_level;
    logic          full;
    logic [CW-1:0] ovf_cnt, drop_cnt;
    logic          cnt_clr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hb_up2_axis_pack #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH_LOG2(FL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din0(din0),
        .din1(din1),
        .din_ovf(din_ovf),
        .din_valid(din_valid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level),
        .full(full),
        .ovf_cnt(ovf_cnt),
        .drop_cnt(drop_cnt),
        .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          ovf;
        logic          tready;
        logic          clr;
        logic          e_valid;
        logic [2*DW-1:0] e_data;
        logic          e_user;
        logic [FL:0]   e_level;
        logic          e_full;
        logic [CW-1:0] e_ovf;
        logic [CW-1:0] e_drop;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        din_valid     = v.valid;
        din0          = v.d0;
        din1          = v.d1;
        din_ovf       = v.ovf;
        m_axis_tready = v.tready;
        cnt_clr       = v.clr;
        tick();
    endtask

    task automatic pushPair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic o);
        din_valid = 1'b1;
        din0      = a;
        din1      = b;
        din_ovf   = o;
        tick();
        din_valid = 1'b0;
        din_ovf   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din0 = '0; din1 = '0; din_ovf = 1'b0; din_valid = 1'b0;
        m_axis_tready = 1'b0; cnt_clr = 1'b0;

        //               valid d0        d1        ovf rdy clr  eV  eData         eU  lvl eF eOvf eDrop
        vecs[0] = '{1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABCD1234, 1'b0, 5'd1, 1'b0, 4'd0, 4'd0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 5'd0, 1'b0, 4'd0, 4'd0};
        vecs[2] = '{1'b1, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 5'd1, 1'b0, 4'd1, 4'd0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 5'd2, 1'b0, 4'd1, 4'd0};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000FFFF, 1'b0, 5'd1, 1'b0, 4'd1, 4'd0};
        vecs[5] = '{1'b1, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000FFFF, 1'b0, 5'd2, 1'b0, 4'd0, 4'd0};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A55A5A, 1'b1, 5'd1, 1'b0, 4'd0, 4'd0};
        vecs[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 5'd0, 1'b0, 4'd0, 4'd0};

        tick();
        tick();
        checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("reset_level", fifo_level, 5'd0);
        checkOutput("reset_full", full, 1'b0);
        checkOutput("reset_ovf_cnt", ovf_cnt, 4'd0);
        checkOutput("reset_drop_cnt", drop_cnt, 4'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].e_data);
                checkOutput($sformatf("vec%0d_tuser", i), m_axis_tuser, vecs[i].e_user);
            end
            checkOutput($sformatf("vec%0d_level", i), fifo_level, vecs[i].e_level);
            checkOutput($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            checkOutput($sformatf("vec%0d_ovf_cnt", i), ovf_cnt, vecs[i].e_ovf);
            checkOutput($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].e_drop);
        end
        din_valid = 1'b0; cnt_clr = 1'b0;

        // Fill with backpressure: 20 pairs, last 4 dropped.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pushPair(16'(i), 16'hC000 | 16'(i), 1'b0);
            if (i == 14) checkOutput("fill_not_full_15", full, 1'b0);
            if (i == 15) begin
                checkOutput("fill_full_16", full, 1'b1);
                checkOutput("fill_level_16", fifo_level, 5'd16);
            end
        end
        checkOutput("fill_drop_cnt", drop_cnt, 4'd4);
        checkOutput("fill_level_end", fifo_level, 5'd16);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_tvalid", m_axis_tvalid, 1'b1);
            checkOutput($sformatf("drain_tdata%0d", i), m_axis_tdata, {16'hC000 | 16'(i), 16'(i)});
            tick();
        end
        checkOutput("drain_tvalid_low", m_axis_tvalid, 1'b0);
        checkOutput("drain_level_zero", fifo_level, 5'd0);

        // Full FIFO with a coincident pop still accepts the incoming pair.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) pushPair(16'h2000 | 16'(i), 16'h3000 | 16'(i), 1'b0);
        checkOutput("fp_full_before", full, 1'b1);
        m_axis_tready = 1'b1;
        pushPair(16'h7777, 16'h8888, 1'b0);
        checkOutput("fp_level", fifo_level, 5'd16);
        checkOutput("fp_full_after", full, 1'b1);
        checkOutput("fp_drop_cnt", drop_cnt, 4'd4);
        for (int i = 1; i < 17; i++) begin
            if (i < 16) checkOutput($sformatf("fp_tdata%0d", i), m_axis_tdata, {16'h3000 | 16'(i), 16'h2000 | 16'(i)});
            else        checkOutput("fp_tdata_last", m_axis_tdata, 32'h88887777);
            tick();
        end
        checkOutput("fp_empty", m_axis_tvalid, 1'b0);

        // Overflow tagging: two stored ovf pairs, one dropped while full.
        m_axis_tready = 1'b0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        checkOutput("ovf_cleared_drop", drop_cnt, 4'd0);
        for (int i = 0; i < 17; i++) pushPair(16'h4000 | 16'(i), 16'h5000 | 16'(i), i >= 14);
        checkOutput("ovf_ovf_cnt", ovf_cnt, 4'd2);
        checkOutput("ovf_drop_cnt", drop_cnt, 4'd1);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("ovf_tdata%0d", i), m_axis_tdata, {16'h5000 | 16'(i), 16'h4000 | 16'(i)});
            checkOutput($sformatf("ovf_tuser%0d", i), m_axis_tuser, i >= 14);
            tick();
        end

        // Drop counter saturation at 2^CW-1.
        m_axis_tready = 1'b0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) pushPair(16'h6000 | 16'(i), 16'h7000 | 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            pushPair(16'hDEAD, 16'hDEAD, 1'b0);
            if (i == 14) checkOutput("sat_drop_15", drop_cnt, 4'd15);
        end
        checkOutput("sat_drop_hold", drop_cnt, 4'd15);
        checkOutput("sat_ovf_zero", ovf_cnt, 4'd0);

        // Asynchronous reset with 7 words buffered.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        m_axis_tready = 1'b0;
        checkOutput("rst_pre_level", fifo_level, 5'd7);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_async_level", fifo_level, 5'd0);
        checkOutput("rst_async_drop", drop_cnt, 4'd0);
        checkOutput("rst_async_full", full, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        pushPair(16'hCAFE, 16'hBEEF, 1'b0);
        checkOutput("rst_after_tvalid", m_axis_tvalid, 1'b1);
        checkOutput("rst_after_tdata", m_axis_tdata, 32'hBEEFCAFE);
        checkOutput("rst_after_level", fifo_level, 5'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
